// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed data RAM: byte/half/word loads with extension,
// sub-word stores via read-modify-write. Optional misaligned-access trap under MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t state, state_n;

    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic              misalign_c;
    logic [DATA_W-1:0] merge_c;
    logic [DATA_W-1:0] load_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state, lane merge for sub-word stores and load extraction
    always_comb begin
        state_n    = state;
        misalign_c = 1'b0;
        merge_c    = mem_rdata;
        byte_c     = mem_rdata[{lane_q, 3'b000} +: 8];
        half_c     = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        load_c     = mem_rdata;

`ifdef MISALIGN_TRAP_EN
        misalign_c = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`endif

        if (size_q == 2'b00) begin
            merge_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            load_c = uns_q ? {{(DATA_W-8){1'b0}}, byte_c} : {{(DATA_W-8){byte_c[7]}}, byte_c};
        end else if (size_q == 2'b01) begin
            merge_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            load_c = uns_q ? {{(DATA_W-16){1'b0}}, half_c} : {{(DATA_W-16){half_c[15]}}, half_c};
        end

        case (state)
            IDLE: begin
                if (req) begin
                    if (misalign_c)   state_n = DONE;
                    else if (!we)     state_n = RD;
                    else if (size[1]) state_n = WR;
                    else              state_n = RD;
                end
            end
            RD:      state_n = we_q ? WR : DONE;
            WR:      state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
        end else begin
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
            mem_read  <= (state_n == RD);
            mem_write <= (state_n == WR);

            if (state == IDLE && req) begin
                we_q     <= we;
                uns_q    <= unsigned_ld;
                size_q   <= size;
                lane_q   <= addr[1:0];
                wdata_q  <= wdata[15:0];
                err      <= misalign_c;
                mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                if (state_n == WR) mem_wdata <= wdata;
            end

            // Word read in RD feeds either the store merge or the load result
            if (state == RD) begin
                if (we_q) mem_wdata <= merge_c;
                else      rdata     <= load_c;
            end

            if (state_n == IDLE) begin
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected completions and RAM writes,
// a negedge monitor checks them against done and mem_write.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [16];
    int          cyc = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    exp_t  sbq[$];
    wexp_t wq[$];

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: completions, RAM writes, and phase counting
    initial begin
        exp_t  e;
        wexp_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_read && mem_write) check("rd_wr_overlap", 32'd1, 32'd0);
                if (mem_read) rd_cnt++;
                if (mem_write) begin
                    wr_cnt++;
                    if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                    else begin
                        w = wq.pop_front();
                        check("mem_addr_wr", mem_addr, w.addr);
                        check("mem_wdata", mem_wdata, w.data);
                    end
                end
                if (done) begin
                    if (sbq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                    else begin
                        e = sbq.pop_front();
                        check("done_cycle", 32'(cyc), 32'(e.cyc));
                        check("err", {31'd0, err}, {31'd0, e.err});
                        if (e.chk_rdata) check("rdata", rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 10);
        if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic access(input string name, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input bit chkr, input int lat,
                          input int nrd, input int nwr, input logic [31:0] wexp);
        int r0, w0;
        @(negedge clk);
        r0 = rd_cnt;
        w0 = wr_cnt;
        we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd; req = 1'b1;
        sbq.push_back('{er, ee, chkr, cyc + lat});
        if (nwr > 0) wq.push_back('{{a[31:2], 2'b00}, wexp});
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; size = ~sz; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        wait_done(name);
        @(negedge clk);
        check({name, "_reads"}, 32'(rd_cnt - r0), 32'(nrd));
        check({name, "_writes"}, 32'(wr_cnt - w0), 32'(nwr));
    endtask

    initial begin
        int r0, w0, t;
        foreach (mem[i]) mem[i] = 32'h0;
        mem[5] = 32'h1122_3344;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        #13;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rw", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //      name      we sz    u     addr    wdata         exp_rdata     err chk lat rd wr  wexp
        access("sw",      1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 2, 0, 1, 32'hDEADBEEF);
        access("lw",      0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 2, 1, 0, 32'h0);
        access("sb",      1, 2'b00, 0, 32'h12, 32'h0000_0055, 32'h0,       0, 0, 3, 1, 1, 32'hDE55BEEF);
        access("lb",      0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 1, 2, 1, 0, 32'h0);
        access("lbu",     0, 2'b00, 1, 32'h13, 32'h0,        32'h000000DE, 0, 1, 2, 1, 0, 32'h0);
        access("lh",      0, 2'b01, 0, 32'h10, 32'h0,        32'hFFFFBEEF, 0, 1, 2, 1, 0, 32'h0);
        access("lhu",     0, 2'b01, 1, 32'h12, 32'h0,        32'h0000DE55, 0, 1, 2, 1, 0, 32'h0);
        access("sh",      1, 2'b01, 0, 32'h16, 32'hFFFF_CAFE, 32'h0,       0, 0, 3, 1, 1, 32'hCAFE3344);
        access("sb0",     1, 2'b00, 0, 32'h14, 32'h1234_5699, 32'h0,       0, 0, 3, 1, 1, 32'hCAFE3399);
        access("lh_hi",   0, 2'b01, 0, 32'h16, 32'h0,        32'hFFFFCAFE, 0, 1, 2, 1, 0, 32'h0);
        access("lbu1",    0, 2'b00, 1, 32'h15, 32'h0,        32'h00000033, 0, 1, 2, 1, 0, 32'h0);
        access("lw_sz3",  0, 2'b11, 0, 32'h14, 32'h0,        32'hCAFE3399, 0, 1, 2, 1, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        access("lw_mis",  0, 2'b10, 0, 32'h11, 32'h0,        32'h0,        1, 0, 1, 0, 0, 32'h0);
        access("lhu_mis", 0, 2'b01, 1, 32'h13, 32'h0,        32'h0,        1, 0, 1, 0, 0, 32'h0);
        access("sw_mis",  1, 2'b10, 0, 32'h16, 32'h0BAD_0BAD, 32'h0,       1, 0, 1, 0, 0, 32'h0);
`else
        access("lw_mis",  0, 2'b10, 0, 32'h11, 32'h0,        32'hDE55BEEF, 0, 1, 2, 1, 0, 32'h0);
        access("lhu_mis", 0, 2'b01, 1, 32'h13, 32'h0,        32'h0000DE55, 0, 1, 2, 1, 0, 32'h0);
`endif
        check("mem_0x14", mem[5], 32'hCAFE3399);

        // req held high with changing fields while busy: only the first access runs
        @(negedge clk);
        r0 = rd_cnt; w0 = wr_cnt;
        we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h14; wdata = 32'h0; req = 1'b1;
        sbq.push_back('{32'hCAFE3399, 1'b0, 1'b1, cyc + 2});
        @(posedge clk);
        #1;
        we = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'hFFFF_FFFF;
        wait_done("held");
        #1;
        req = 1'b0;
        @(negedge clk);
        check("held_reads", 32'(rd_cnt - r0), 32'd1);
        check("held_writes", 32'(wr_cnt - w0), 32'd0);
        check("held_mem_0x10", mem[4], 32'hDE55BEEF);

        // reset during the WR cycle of a byte store
        @(negedge clk);
        we = 1'b1; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h10; wdata = 32'h77; req = 1'b1;
        wq.push_back('{32'h10, 32'hDE55BE77});
        @(posedge clk);
        #1;
        req = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_write && t < 10);
        if (!mem_write) check("rst_wr_timeout", 32'd1, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rstwr_mem_write", {31'd0, mem_write}, 32'd0);
        check("rstwr_busy", {31'd0, busy}, 32'd0);
        check("rstwr_done", {31'd0, done}, 32'd0);
        check("rstwr_rdata", rdata, 32'd0);
        check("rstwr_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        check("rstwr_mem_0x10", mem[4], 32'hDE55BEEF);
        @(negedge clk);
        rst = 1'b0;

        access("lw_after", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, 1, 2, 1, 0, 32'h0);
        check("sbq_empty", 32'(sbq.size()), 32'd0);
        check("wq_empty", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator that sits between the datapath's load/store stage and the word-addressed data RAM. It converts byte, halfword and word loads and stores into RAM read and write cycles. Sub-word stores are performed as read-modify-write. Loaded data is extracted, sign- or zero-extended, and returned to the datapath with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; only 32 is supported.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  encoding: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- unsigned_ld  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- addr  in  ADDR_W  byte address of the access.
- wdata  in  32  store data, right-aligned.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load result; held until the next load completes.
- err  out  1  misalignment flag; valid while done is high.
- mem_read  out  1  RAM read enable.
- mem_write  out  1  RAM write enable.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; combinational and valid in the same cycle as mem_read.

## Operation
- States: IDLE, RD, WR, DONE.
- Acceptance:
  - When req=1 in IDLE, the block latches we, size, unsigned_ld, addr and wdata at the clock edge.
  - After that edge, changes on the request inputs have no effect on the access in flight.
  - req is ignored in every other state.
- Transitions from IDLE:
  - Load: IDLE→RD→DONE→IDLE.
  - Word store: IDLE→WR→DONE→IDLE.
  - Byte or half store: IDLE→RD→WR→DONE→IDLE.
- RD state:
  - mem_read=1 and mem_write=0.
  - mem_rdata is captured into the internal word register at the end of the cycle.
- WR state:
  - mem_write=1 and mem_read=0.
  - mem_wdata = wdata for a word store.
  - For a sub-word store, mem_wdata = captured word with the target lane replaced.
- Lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Loads:
  - The selected lane is extended to 32 bits per unsigned_ld.
  - rdata is updated on the edge entering DONE.
- mem_addr and mem_wdata are registered. Both read 0 in IDLE.
- done=1 only in DONE. err is cleared on every new acceptance.

## Timing
- Cycle n: req=1 while in IDLE; the request is accepted at the end of the cycle.
- Load and word store: done=1 in cycle n+2.
- Sub-word store:
  - RD in cycle n+1, WR in cycle n+2.
  - done=1 in cycle n+3.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE, since busy stays 1 through DONE.
- mem_read and mem_write are never both 1. Each is asserted for exactly one cycle per access phase.
- Reset:
  - All outputs go to 0 and the state goes to IDLE immediately, without waiting for a clock edge.
  - Reset asserted mid-RD or mid-WR drops mem_write before the next edge, so no partial write occurs.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses are a half with addr[0]=1, or a word with addr[1:0]≠00.
  - Such an access goes IDLE→DONE with err=1 and issues no RAM cycle.
  - rdata is unchanged for the trapped access.
- MISALIGN_TRAP_EN undefined:
  - err is tied to 0.
  - For a word access, addr[1:0] is ignored.
  - For a half access, addr[0] is ignored.
  - The access proceeds as aligned.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> rdata=0xDEADBEEF. Store done in cycle n+2. mem_addr=0x10.
- With word 0xDEADBEEF at 0x10, byte store 0x55 to 0x12 -> one mem_read cycle, then one mem_write cycle with mem_wdata=0xDE55BEEF. done in cycle n+3.
- Loads from word 0xDE55BEEF at 0x10:
  - Signed byte at 0x13 -> 0xFFFFFFDE.
  - Unsigned byte at 0x13 -> 0x000000DE.
  - Signed half at 0x10 -> 0xFFFFBEEF.
  - Unsigned half at 0x12 -> 0x0000DE55.
- Word load at 0x11:
  - With MISALIGN_TRAP_EN: err=1 with done in cycle n+1, mem_read never asserted.
  - Without the macro: mem_addr=0x10 and rdata equals the word at 0x10.
- rst=1 during the WR cycle of a byte store -> mem_write=0 immediately, RAM word unchanged, busy, done and rdata all 0, state IDLE.
- req held at 1 with differing addr while busy -> only the first request executes. A second access starts only once IDLE is re-entered.
